// File: rtl/emif_seq_mem_arbiter.sv
// Two-master Avalon-MM round-robin arbiter in front of the sequencer's single-port soft M20K.
// One access per cycle. It returns read data one cycle after the grant and gates host writes.
module emif_seq_mem_arbiter #(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned DATA_W        = 32,
  parameter bit          M0_PRIO_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  // Master 0: calibration CPU data port
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  output logic                m0_waitrequest_o,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  // Master 1: host/debug port
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  output logic                m1_waitrequest_o,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  input  logic                dbg_write_en_i,
  input  logic                mem_reset_req_i,
  // Memory side
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic [DATA_W/8-1:0] mem_byteenable_o,
  output logic                mem_chipselect_o,
  output logic                mem_write_o,
  output logic                mem_debugaccess_o,
  output logic [DATA_W-1:0]   mem_writedata_o,
  output logic                mem_clken_o,
  input  logic [DATA_W-1:0]   mem_readdata_i,
  output logic                wr_blocked_o,
  output logic                rd_owner_o
);

  logic              req0, req1, gnt0, gnt1, any_gnt, rd_gnt;
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              wr_blocked_q, wr_blocked_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign req0 = m0_read_i | m0_write_i;
  assign req1 = m1_read_i | m1_write_i;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!mem_reset_req_i) begin
      if (req0 && req1) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign any_gnt          = gnt0 | gnt1;
  assign m0_waitrequest_o = req0 & ~gnt0;
  assign m1_waitrequest_o = req1 & ~gnt1;

  // A write on the same master takes precedence over a read.
  assign rd_gnt = (gnt0 & m0_read_i & ~m0_write_i) | (gnt1 & m1_read_i & ~m1_write_i);

  always_comb begin
    mem_address_o    = gnt1 ? m1_address_i    : m0_address_i;
    mem_byteenable_o = gnt1 ? m1_byteenable_i : m0_byteenable_i;
    mem_writedata_o  = gnt1 ? m1_writedata_i  : m0_writedata_i;
    mem_chipselect_o = any_gnt;
    mem_write_o      = (gnt0 & m0_write_i) | (gnt1 & m1_write_i);
    // A host write with debug writes disabled is acknowledged but never lands.
    mem_debugaccess_o = (gnt0 & m0_write_i) | (gnt1 & m1_write_i & dbg_write_en_i);
    mem_clken_o       = any_gnt & ~mem_reset_req_i;
  end

  always_comb begin
    last_grant_d = any_gnt ? gnt1 : last_grant_q;
    rd_pend_d    = rd_gnt;
    rd_owner_d   = rd_gnt ? gnt1 : rd_owner_q;
    wr_blocked_d = wr_blocked_q | (gnt1 & m1_write_i & ~dbg_write_en_i);
    rdata0_d     = m0_readdatavalid_o ? mem_readdata_i : rdata0_q;
    rdata1_d     = m1_readdatavalid_o ? mem_readdata_i : rdata1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // last_grant names the master served last; reset it to master 1 so master 0 wins first.
      last_grant_q <= M0_PRIO_RESET;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      wr_blocked_q <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      wr_blocked_q <= wr_blocked_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // q is unregistered, so the return cycle forwards it directly and the holding register
  // keeps it afterwards.
  assign m0_readdatavalid_o = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid_o = rd_pend_q & rd_owner_q;
  assign m0_readdata_o      = m0_readdatavalid_o ? mem_readdata_i : rdata0_q;
  assign m1_readdata_o      = m1_readdatavalid_o ? mem_readdata_i : rdata1_q;
  assign wr_blocked_o       = wr_blocked_q;
  assign rd_owner_o         = rd_owner_q;

endmodule
